// File: rtl/fxp_utils.sv
// fxp_utils: single-cycle fixed-point arithmetic unit.
// Operands A and B are converted to a common wide signed intermediate, the
// selected operation is computed exactly, then the result is rescaled to the
// output fraction and range-checked. TYPE selects truncate/wrap (INT) or
// round-half-up/saturate (FXP). Result, overflow flag and valid are registered.
module fxp_utils #(
  parameter int TYPE   = 1,
  parameter int A_SIGN = 1,
  parameter int A_PREC = 8,
  parameter int A_FRAC = 3,
  parameter int B_SIGN = 0,
  parameter int B_PREC = 4,
  parameter int B_FRAC = 4,
  parameter int O_SIGN = 1,
  parameter int O_PREC = 16,
  parameter int O_FRAC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [2:0]        op,
  input  logic [A_PREC-1:0] a,
  input  logic [B_PREC-1:0] b,
  output logic              out_valid,
  output logic [O_PREC-1:0] out,
  output logic              ovf
);

  localparam logic [2:0] OP_CONV = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_NEG  = 3'd4;
  localparam logic [2:0] OP_MAX  = 3'd5;
  localparam logic [2:0] OP_MIN  = 3'd6;

  // Fraction bits of the exact intermediate for each operation class.
  localparam int F_AB  = (A_FRAC > B_FRAC) ? A_FRAC : B_FRAC;
  localparam int F_MUL = A_FRAC + B_FRAC;
  localparam int F_DIF = (A_FRAC > B_FRAC) ? (A_FRAC - B_FRAC) : (B_FRAC - A_FRAC);

  // Internal width covers alignment, the full product, the largest left
  // rescale and the output range compare, so nothing ever wraps inside.
  localparam int RW = A_PREC + B_PREC + F_DIF + O_PREC + O_FRAC + 4;

  localparam logic signed [RW-1:0] ONE   = {{(RW-1){1'b0}}, 1'b1};
  localparam logic signed [RW-1:0] O_MAX = (O_SIGN != 0) ? (ONE <<< (O_PREC - 1)) - ONE
                                                         : (ONE <<< O_PREC) - ONE;
  localparam logic signed [RW-1:0] O_MIN = (O_SIGN != 0) ? -(ONE <<< (O_PREC - 1))
                                                         : {RW{1'b0}};

  // Move a value with f fraction bits to O_FRAC fraction bits.
  // Right shifts round half-up in FXP mode and floor in INT mode.
  function automatic logic signed [RW-1:0] rescale(input logic signed [RW-1:0] v,
                                                   input int f);
    logic signed [RW-1:0] rnd;
    rnd = '0;
    if (O_FRAC >= f) begin
      rescale = v <<< (O_FRAC - f);
    end else begin
      if (TYPE != 0) rnd = ONE <<< (f - O_FRAC - 1);
      rescale = (v + rnd) >>> (f - O_FRAC);
    end
  endfunction

  logic                     a_msb, b_msb;
  logic signed [RW-1:0]     a_ext, b_ext, a_aln, b_aln;
  logic signed [RW-1:0]     res;
  logic                     over, under;
  logic [O_PREC-1:0]        res_out;

  logic                     out_valid_d, out_valid_q;
  logic [O_PREC-1:0]        out_d, out_q;
  logic                     ovf_d, ovf_q;

  // Extend operands to the internal width and align them for add/compare.
  always_comb begin
    a_msb = (A_SIGN != 0) & a[A_PREC-1];
    b_msb = (B_SIGN != 0) & b[B_PREC-1];
    a_ext = {{(RW-A_PREC){a_msb}}, a};
    b_ext = {{(RW-B_PREC){b_msb}}, b};
    a_aln = a_ext <<< (F_AB - A_FRAC);
    b_aln = b_ext <<< (F_AB - B_FRAC);
  end

  // Compute the exact result, rescale it, then range-check and clamp or wrap.
  always_comb begin
    case (op)
      OP_ADD:  res = rescale(a_aln + b_aln, F_AB);
      OP_SUB:  res = rescale(a_aln - b_aln, F_AB);
      OP_MUL:  res = rescale(a_ext * b_ext, F_MUL);
      OP_NEG:  res = rescale(-a_ext, A_FRAC);
      OP_MAX:  res = rescale((a_aln >= b_aln) ? a_aln : b_aln, F_AB);
      OP_MIN:  res = rescale((a_aln <= b_aln) ? a_aln : b_aln, F_AB);
      default: res = rescale(a_ext, A_FRAC);  // CONV and the reserved code
    endcase
    over  = (res > O_MAX);
    under = (res < O_MIN);
    if (TYPE != 0 && over)       res_out = O_MAX[O_PREC-1:0];
    else if (TYPE != 0 && under) res_out = O_MIN[O_PREC-1:0];
    else                         res_out = res[O_PREC-1:0];
  end

  // Capture a new result only when an op is presented; otherwise hold.
  always_comb begin
    out_valid_d = in_valid;
    out_d       = out_q;
    ovf_d       = ovf_q;
    if (in_valid) begin
      out_d = res_out;
      ovf_d = over | under;
    end
  end

  // Output registers; an op presented while reset is high is simply dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fxp_utils.sv
// Directed bench for fxp_utils: five instances with different output formats
// and rounding modes share one stimulus stream.
module tb_fxp_utils;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [2:0] op;
  logic [7:0] a;
  logic [3:0] b;

  logic        vld_f, vld_i, vld_8f, vld_8i, vld_u;
  logic [15:0] out_f, out_i;
  logic [7:0]  out_8f, out_8i, out_u;
  logic        ovf_f, ovf_i, ovf_8f, ovf_8i, ovf_u;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fxp_utils #(.TYPE(1)) dut_f (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .out_valid(vld_f), .out(out_f), .ovf(ovf_f));

  fxp_utils #(.TYPE(0)) dut_i (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .out_valid(vld_i), .out(out_i), .ovf(ovf_i));

  fxp_utils #(.TYPE(1), .O_PREC(8), .O_FRAC(3)) dut_8f (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .out_valid(vld_8f), .out(out_8f), .ovf(ovf_8f));

  fxp_utils #(.TYPE(0), .O_PREC(8), .O_FRAC(3)) dut_8i (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .out_valid(vld_8i), .out(out_8i), .ovf(ovf_8i));

  fxp_utils #(.TYPE(1), .O_SIGN(0), .O_PREC(8), .O_FRAC(3)) dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .out_valid(vld_u), .out(out_u), .ovf(ovf_u));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one op on the falling edge, sample 1 ns after the next rising edge.
  task automatic apply(input logic [2:0] o, input logic [7:0] av, input logic [3:0] bv);
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    op       = 3'd0;
    a        = 8'h00;
    b        = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_vld", {31'd0, vld_f}, 32'd0);
    check("rst_out", {16'd0, out_f}, 32'd0);
    check("rst_ovf", {31'd0, ovf_f}, 32'd0);
    reset = 1'b0;

    apply(3'd1, 8'h08, 4'h8);
    check("add_out", {16'd0, out_f}, 32'h0018);
    check("add_ovf", {31'd0, ovf_f}, 32'd0);
    check("add_vld", {31'd0, vld_f}, 32'd1);

    idle();
    check("hold_vld", {31'd0, vld_f}, 32'd0);
    check("hold_out", {16'd0, out_f}, 32'h0018);

    apply(3'd3, 8'hF8, 4'h8);
    check("mul_f", {16'd0, out_f}, 32'hFFF8);
    check("mul_i", {16'd0, out_i}, 32'hFFF8);
    check("mul_f_ovf", {31'd0, ovf_f}, 32'd0);

    apply(3'd1, 8'h7F, 4'hF);
    check("sat_8f", {24'd0, out_8f}, 32'h7F);
    check("sat_8f_ovf", {31'd0, ovf_8f}, 32'd1);
    check("wrap_8i", {24'd0, out_8i}, 32'h86);
    check("wrap_8i_ovf", {31'd0, ovf_8i}, 32'd1);

    apply(3'd3, 8'h01, 4'h8);
    check("rnd_8f", {24'd0, out_8f}, 32'h01);
    check("trn_8i", {24'd0, out_8i}, 32'h00);

    apply(3'd2, 8'h08, 4'h8);
    check("sub_f", {16'd0, out_f}, 32'h0008);

    apply(3'd4, 8'h08, 4'h0);
    check("neg_f", {16'd0, out_f}, 32'hFFF0);
    check("neg_u", {24'd0, out_u}, 32'h00);
    check("neg_u_ovf", {31'd0, ovf_u}, 32'd1);

    apply(3'd4, 8'h80, 4'h0);
    check("negmin_8f", {24'd0, out_8f}, 32'h7F);
    check("negmin_8f_ovf", {31'd0, ovf_8f}, 32'd1);
    check("negmin_8i", {24'd0, out_8i}, 32'h80);
    check("negmin_8i_ovf", {31'd0, ovf_8i}, 32'd1);
    check("negmin_f", {16'd0, out_f}, 32'h0100);
    check("negmin_f_ovf", {31'd0, ovf_f}, 32'd0);

    apply(3'd0, 8'h7F, 4'h0);
    check("bnd_hi", {24'd0, out_8f}, 32'h7F);
    check("bnd_hi_ovf", {31'd0, ovf_8f}, 32'd0);

    apply(3'd0, 8'h80, 4'h0);
    check("bnd_lo", {24'd0, out_8f}, 32'h80);
    check("bnd_lo_ovf", {31'd0, ovf_8f}, 32'd0);

    apply(3'd7, 8'h08, 4'h0);
    check("op7_conv", {16'd0, out_f}, 32'h0010);

    apply(3'd3, 8'h05, 4'h1);
    check("mulr_f", {16'd0, out_f}, 32'h0001);
    check("mulr_i", {16'd0, out_i}, 32'h0000);

    apply(3'd3, 8'hFC, 4'h1);
    check("mulh_f", {16'd0, out_f}, 32'h0000);
    check("mulh_i", {16'd0, out_i}, 32'hFFFF);

    apply(3'd5, 8'hF8, 4'h8);
    check("max_neg", {16'd0, out_f}, 32'h0008);
    apply(3'd6, 8'hF8, 4'h8);
    check("min_neg", {16'd0, out_f}, 32'hFFF0);

    apply(3'd1, 8'h00, 4'hF);
    check("b_unsigned", {16'd0, out_f}, 32'h000F);

    idle();
    apply(3'd5, 8'h08, 4'h8);
    check("b2b_max", {16'd0, out_f}, 32'h0010);
    check("b2b_vld0", {31'd0, vld_f}, 32'd1);
    apply(3'd6, 8'h08, 4'h8);
    check("b2b_min", {16'd0, out_f}, 32'h0008);
    check("b2b_vld1", {31'd0, vld_f}, 32'd1);

    @(negedge clk);
    in_valid = 1'b1;
    op       = 3'd1;
    a        = 8'h08;
    b        = 4'h8;
    reset    = 1'b1;
    #1;
    check("mrst_vld", {31'd0, vld_f}, 32'd0);
    check("mrst_out", {16'd0, out_f}, 32'd0);
    check("mrst_ovf", {31'd0, ovf_8f}, 32'd0);
    @(posedge clk);
    #1;
    check("mrst_drop", {31'd0, vld_f}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    op    = 3'd0;
    a     = 8'h08;
    b     = 4'h0;
    @(posedge clk);
    #1;
    check("post_rst_out", {16'd0, out_f}, 32'h0010);
    check("post_rst_vld", {31'd0, vld_f}, 32'd1);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fxp_utils.md
FXP_UTILS -- requirements
Module: fxp_utils

Interface
REQ-001 SHALL have parameter TYPE, default FXP (1), data type: INT (0) = truncate and wrap, FXP (1) = round and saturate.
REQ-002 SHALL have parameters A_SIGN, default 1; A_PREC, default 8; A_FRAC, default 3: operand A signedness, total width, fraction bits.
REQ-003 SHALL have parameters B_SIGN, default 0; B_PREC, default 4; B_FRAC, default 4: operand B format.
REQ-004 SHALL have parameters O_SIGN, default 1; O_PREC, default 16; O_FRAC, default 4: result format.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 SHALL have these ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- in_valid  input  1  operands and op valid this cycle.
- op  input  3  0 CONV(A), 1 ADD, 2 SUB (A-B), 3 MUL, 4 NEG(A), 5 MAX, 6 MIN, 7 reserved.
- a  input  A_PREC  operand A; value = a * 2^-A_FRAC.
- b  input  B_PREC  operand B; value = b * 2^-B_FRAC.
- out_valid  output  1  result valid.
- out  output  O_PREC  result in O format.
- ovf  output  1  result exceeded O range.

Function
REQ-007 SHALL interpret a field as two's complement when its SIGN is 1 and as unsigned when its SIGN is 0.
REQ-008 SHALL compute an exact intermediate with no loss:
- ADD, SUB, MAX, MIN: operands aligned to max(A_FRAC, B_FRAC) fraction bits.
- MUL: A_FRAC + B_FRAC fraction bits.
- CONV, NEG: A_FRAC fraction bits.
The intermediate SHALL be wide enough that it never wraps.
REQ-009 SHALL rescale the intermediate to O_FRAC:
- left shift when O_FRAC is larger; this is exact.
- right shift when O_FRAC is smaller: INT truncates toward negative infinity (arithmetic shift); FXP rounds half-up (add 2^(shift-1), then shift).
REQ-010 SHALL define the O range as [-2^(O_PREC-1), 2^(O_PREC-1)-1] when O_SIGN=1 and [0, 2^O_PREC-1] when O_SIGN=0.
REQ-011 SHALL assert ovf when the rescaled value is outside the O range. On overflow, FXP clamps to the nearest bound and INT keeps the low O_PREC bits (wrap).
REQ-012 SHALL register out, ovf and out_valid, giving latency exactly 1 cycle: out_valid(t+1) = in_valid(t). There is no backpressure, and one op is accepted per cycle.
REQ-013 SHALL hold out and ovf at their last values while out_valid=0.
REQ-014 SHALL treat op=7 as CONV(A).
REQ-015 SHALL treat NEG of the most negative value and NEG of any nonzero A with O_SIGN=0 as ordinary overflow under REQ-011.
REQ-016 SHALL resolve ties in MAX and MIN by returning A.
REQ-017 SHALL set ovf=0 when the result is in range, including exactly at a bound.

Reset
REQ-018 SHALL force out_valid=0, out=0 and ovf=0 asynchronously while reset=1.
REQ-019 SHALL discard an operation accepted in the cycle reset asserts; no out_valid is produced for it.
REQ-020 SHALL accept a new operation on the first clock edge after reset deasserts.

Verification
REQ-021 Defaults, FXP: op=ADD, a=8'h08 (1.0), b=4'h8 (0.5), in_valid=1 -> next cycle out=16'h0018 (1.5), ovf=0, out_valid=1.
REQ-022 Defaults: op=MUL, a=8'hF8 (-1.0), b=4'h8 (0.5) -> out=16'hFFF8 (-0.5), ovf=0, in both INT and FXP.
REQ-023 O_PREC=8, O_FRAC=3, op=ADD, a=8'h7F, b=4'hF -> FXP gives out=8'h7F, ovf=1; INT gives out=8'h86, ovf=1.
REQ-024 O_PREC=8, O_FRAC=3, op=MUL, a=8'h01, b=4'h8 -> FXP gives out=8'h01 (rounded up); INT gives out=8'h00.
REQ-025 Back-to-back: ops MAX(a=8'h08, b=4'h8) then MIN(a=8'h08, b=4'h8) on consecutive cycles -> out=16'h0010 then 16'h0008, with out_valid high for 2 consecutive cycles.
REQ-026 Mid-operation reset: assert reset in the same cycle in_valid=1 -> out_valid=0, out=0, ovf=0 immediately. After release, a CONV of a=8'h08 returns 16'h0010 one cycle later.
